// File: rtl/rpm_gauge_engine.sv
// Engine level keeper with gear-derived limit, rev-limiter decay after a downshift,
// and registered LED bar / blinking RGB stage indicator for the 1 kHz tick domain.
module rpm_gauge_engine #(
    parameter int LEVEL_W      = 4,
    parameter int NUM_GEARS    = 5,
    parameter int GEAR_W       = 3,
    parameter int GEAR_STEP    = 3,
    parameter int BAR_SEGS     = 8,
    parameter int DECAY_CYCLES = 200,
    parameter int BLINK_CYCLES = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                accel_pulse,
    input  logic                decel_pulse,
    input  logic [GEAR_W-1:0]   gear,
    output logic [LEVEL_W-1:0]  speed_level,
    output logic [LEVEL_W-1:0]  max_level,
    output logic                limiting,
    output logic [1:0]          stage,
    output logic [2:0]          rgb,
    output logic [BAR_SEGS-1:0] bar
);

    localparam int LEVEL_MAX = (2 ** LEVEL_W) - 1;
    localparam int PROD_W    = LEVEL_W + $clog2(BAR_SEGS) + 1;
    localparam int DECAY_W   = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam int BLINK_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_OFF    = 3'b000;

    typedef enum logic {
        RUN   = 1'b0,
        DECAY = 1'b1
    } fsm_t;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        CAUTION = 2'd1,
        DANGER  = 2'd2
    } stage_t;

    fsm_t                 state;
    fsm_t                 state_next;
    stage_t               stage_q;
    stage_t               stage_next;
    logic [LEVEL_W-1:0]   speed_next;
    logic [LEVEL_W-1:0]   max_next;
    logic [DECAY_W-1:0]   decay_cnt;
    logic [DECAY_W-1:0]   decay_cnt_next;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [BLINK_W-1:0]   blink_cnt_next;
    logic                 blink_on;
    logic                 blink_on_next;
    logic [2:0]           rgb_next;
    logic [BAR_SEGS-1:0]  bar_next;
    logic [LEVEL_W-1:0]   half_max;
    logic [PROD_W-1:0]    speed_scaled;
    logic [PROD_W-1:0]    seg_thresh;
    int                   gear_eff;
    int                   limit_raw;

    // Gear limit: out-of-range gears saturate to the top gear, result saturates to the level range.
    always_comb begin
        gear_eff  = (int'(gear) > NUM_GEARS) ? NUM_GEARS : int'(gear);
        limit_raw = gear_eff * GEAR_STEP;
        if (limit_raw > LEVEL_MAX) begin
            limit_raw = LEVEL_MAX;
        end
        max_next = LEVEL_W'(limit_raw);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // In DECAY a manual decel takes effect at once and restarts the automatic drop interval.
    always_comb begin
        state_next     = state;
        speed_next     = speed_level;
        decay_cnt_next = decay_cnt;
        case (state)
            RUN: begin
                decay_cnt_next = '0;
                if (accel_pulse && !decel_pulse && (speed_level < max_level)) begin
                    speed_next = speed_level + 1'b1;
                end else if (decel_pulse && !accel_pulse && (speed_level != '0)) begin
                    speed_next = speed_level - 1'b1;
                end
                if (speed_level > max_level) begin
                    state_next = DECAY;
                end
            end
            DECAY: begin
                if (decel_pulse) begin
                    decay_cnt_next = '0;
                    if (speed_level != '0) begin
                        speed_next = speed_level - 1'b1;
                    end
                end else if (speed_level > max_level) begin
                    if (decay_cnt == DECAY_W'(DECAY_CYCLES - 1)) begin
                        decay_cnt_next = '0;
                        speed_next     = speed_level - 1'b1;
                    end else begin
                        decay_cnt_next = decay_cnt + 1'b1;
                    end
                end
                if (speed_level <= max_level) begin
                    state_next     = RUN;
                    decay_cnt_next = '0;
                end
            end
            default: begin
                state_next     = RUN;
                decay_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        half_max = max_level >> 1;
        if ((state == DECAY) ||
            ((max_level != '0) && (speed_level >= max_level) && (speed_level != '0))) begin
            stage_next = DANGER;
        end else if ((speed_level >= half_max) && (speed_level != '0)) begin
            stage_next = CAUTION;
        end else begin
            stage_next = NORMAL;
        end
    end

    // Blink phase restarts lit on every entry into DANGER so the first red period is always full.
    always_comb begin
        blink_cnt_next = '0;
        blink_on_next  = 1'b0;
        rgb_next       = RGB_GREEN;
        if (stage_next == DANGER) begin
            if (stage_q != DANGER) begin
                blink_on_next = 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_on_next = !blink_on;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
                blink_on_next  = blink_on;
            end
            rgb_next = blink_on_next ? RGB_RED : RGB_OFF;
        end else if (stage_next == CAUTION) begin
            rgb_next = RGB_YELLOW;
        end
    end

    // Thermometer compare done at widened precision so speed*BAR_SEGS never truncates.
    always_comb begin
        bar_next     = '0;
        speed_scaled = PROD_W'(speed_level) * PROD_W'(BAR_SEGS);
        seg_thresh   = '0;
        if (max_level == '0) begin
            bar_next = (speed_level != '0) ? '1 : '0;
        end else if (speed_level >= max_level) begin
            bar_next = '1;
        end else begin
            for (int i = 0; i < BAR_SEGS; i++) begin
                seg_thresh  = PROD_W'(i + 1) * PROD_W'(max_level);
                bar_next[i] = (speed_scaled >= seg_thresh);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_level <= '0;
            max_level   <= '0;
            limiting    <= 1'b0;
            decay_cnt   <= '0;
            stage_q     <= NORMAL;
            blink_cnt   <= '0;
            blink_on    <= 1'b0;
            rgb         <= RGB_GREEN;
            bar         <= '0;
        end else begin
            speed_level <= speed_next;
            max_level   <= max_next;
            limiting    <= (state_next == DECAY);
            decay_cnt   <= decay_cnt_next;
            stage_q     <= stage_next;
            blink_cnt   <= blink_cnt_next;
            blink_on    <= blink_on_next;
            rgb         <= rgb_next;
            bar         <= bar_next;
        end
    end

    assign stage = stage_q;

endmodule
